// File: rtl/spi_seq_pkg.sv
// Shared types for the quad-SPI flash sequencer.
//   seq_state_t    : sequencer states. The encoding is also the LED debug value.
//   pin_owner_t    : which engine currently drives the shared pin set.
//   seq_out_t      : bundle of the state-decoded outputs.
//   decode_outputs : maps a state to its output bundle.
package spi_seq_pkg;

    localparam int QE_BIT_DEF = 6;
    localparam int GUARD_DEF  = 4;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        INIT_RUN    = 3'd1,
        INIT_CHECK  = 3'd2,
        GUARD       = 3'd3,
        READY       = 3'd4,
        READ_ACTIVE = 3'd5,
        ERROR       = 3'd6
    } seq_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        INIT = 2'd1,
        READ = 2'd2
    } pin_owner_t;

    typedef struct packed {
        logic       en_init;
        logic       en_read;
        pin_owner_t pin_owner;
        logic       ready;
        logic       busy;
        logic       error;
    } seq_out_t;

    // Every state that is not listed leaves the pins unowned and both engines off.
    function automatic seq_out_t decode_outputs(input seq_state_t s);
        seq_out_t o;
        o = '0;
        case (s)
            INIT_RUN: begin
                o.en_init   = 1'b1;
                o.pin_owner = INIT;
            end
            READY: begin
                o.en_read   = 1'b1;
                o.pin_owner = READ;
                o.ready     = 1'b1;
            end
            READ_ACTIVE: begin
                o.en_read   = 1'b1;
                o.pin_owner = READ;
                o.ready     = 1'b1;
                o.busy      = 1'b1;
            end
            ERROR: begin
                o.error = 1'b1;
            end
            default: begin
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter with a zero flag.
//   clk, rst_n : clock, synchronous active-low reset (count clears to 0).
//   load       : load load_val (wins over dec).
//   load_val   : value to load.
//   dec        : count down by one; the count holds at 0.
//   zero       : count is 0.
module seq_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/spi_flash_sequencer.sv
// Sequencer for the shared quad-SPI pin set. It runs the init engine, checks
// the quad-enable bit, retries on failure and then serves AXI reads through
// the read engine. Between ownership changes it inserts a guard gap with no
// pin owner.
//   ACLK, ARESETn : clock, synchronous active-low reset.
//   start         : request (re)initialisation (level, sampled each cycle).
//   init_done     : init engine finished; init_status holds the captured status.
//   read_req      : AXI read address valid.
//   read_done     : one-cycle pulse when the read engine completes.
//   en_init/en_read/pin_owner : engine enables and pin mux select.
//   ready, busy, error        : configured / read in flight / init failed.
//   retry_cnt, status_q       : attempts consumed, last latched status.
//   state_dbg                 : current state encoding, for LEDs.
module spi_flash_sequencer
    import spi_seq_pkg::*;
#(
    parameter int QE_BIT       = QE_BIT_DEF,
    parameter int MAX_RETRY    = 3,
    parameter int INIT_TIMEOUT = 4096,
    parameter int GUARD_CYCLES = GUARD_DEF,
    parameter int AUTO_START   = 1
) (
    input  logic       ACLK,
    input  logic       ARESETn,
    input  logic       start,
    input  logic       init_done,
    input  logic [7:0] init_status,
    input  logic       read_req,
    input  logic       read_done,
    output logic       en_init,
    output logic       en_read,
    output logic [1:0] pin_owner,
    output logic       ready,
    output logic       busy,
    output logic       error,
    output logic [1:0] retry_cnt,
    output logic [7:0] status_q,
    output logic [2:0] state_dbg
);

    localparam int INIT_W = $clog2(INIT_TIMEOUT);
    localparam int GUARD_W = $clog2(GUARD_CYCLES + 1);
    localparam logic [INIT_W-1:0]  INIT_LOAD  = INIT_W'(INIT_TIMEOUT - 1);
    localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_CYCLES - 1);
    localparam logic [1:0]         RETRY_MAX  = 2'(MAX_RETRY);

    seq_state_t state_q, state_d;
    seq_state_t guard_next_q, guard_next_d;
    logic [1:0] retry_d;
    logic [7:0] status_d;
    logic       start_pending_q, start_pending_d;
    logic       timed_out_q, timed_out_d;
    logic       auto_arm_q;
    seq_out_t   outs_q, outs_d;

    logic init_tmr_zero, guard_tmr_zero;
    logic init_tmr_load, guard_tmr_load;

    // Timers load on the edge that enters their state and count while in it,
    // so the zero flag marks the last cycle of the allowed window.
    assign init_tmr_load  = (state_d == INIT_RUN) && (state_q != INIT_RUN);
    assign guard_tmr_load = (state_d == GUARD) && (state_q != GUARD);

    seq_timer #(.WIDTH(INIT_W)) u_init_timer (
        .clk      (ACLK),
        .rst_n    (ARESETn),
        .load     (init_tmr_load),
        .load_val (INIT_LOAD),
        .dec      (state_q == INIT_RUN),
        .zero     (init_tmr_zero)
    );

    seq_timer #(.WIDTH(GUARD_W)) u_guard_timer (
        .clk      (ACLK),
        .rst_n    (ARESETn),
        .load     (guard_tmr_load),
        .load_val (GUARD_LOAD),
        .dec      (state_q == GUARD),
        .zero     (guard_tmr_zero)
    );

    // State and sequencing registers.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q         <= IDLE;
            guard_next_q    <= IDLE;
            retry_cnt       <= '0;
            status_q        <= '0;
            start_pending_q <= 1'b0;
            timed_out_q     <= 1'b0;
            auto_arm_q      <= (AUTO_START != 0);
        end else begin
            state_q         <= state_d;
            guard_next_q    <= guard_next_d;
            retry_cnt       <= retry_d;
            status_q        <= status_d;
            start_pending_q <= start_pending_d;
            timed_out_q     <= timed_out_d;
            auto_arm_q      <= 1'b0;
        end
    end

    // Next-state and sequencing decisions.
    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // skipped one would infer a latch.
        state_d         = state_q;
        guard_next_d    = guard_next_q;
        retry_d         = retry_cnt;
        status_d        = status_q;
        start_pending_d = start_pending_q;
        timed_out_d     = timed_out_q;

        case (state_q)
            IDLE: begin
                if (start || auto_arm_q) begin
                    state_d = INIT_RUN;
                end
            end
            INIT_RUN: begin
                // init_done in the last watchdog cycle still counts as done.
                if (init_done) begin
                    status_d    = init_status;
                    timed_out_d = 1'b0;
                    state_d     = INIT_CHECK;
                end else if (init_tmr_zero) begin
                    timed_out_d = 1'b1;
                    state_d     = INIT_CHECK;
                end
            end
            INIT_CHECK: begin
                // A timeout leaves status_q stale, so it must not pass the check.
                if (status_q[QE_BIT] && !timed_out_q) begin
                    guard_next_d = READY;
                    state_d      = GUARD;
                end else if (retry_cnt == RETRY_MAX) begin
                    state_d = ERROR;
                end else begin
                    retry_d      = retry_cnt + 2'd1;
                    guard_next_d = INIT_RUN;
                    state_d      = GUARD;
                end
            end
            GUARD: begin
                if (guard_tmr_zero) begin
                    state_d = guard_next_q;
                end
            end
            READY: begin
                // start wins; read_req stays pending on the bus for later.
                if (start) begin
                    retry_d      = '0;
                    guard_next_d = INIT_RUN;
                    state_d      = GUARD;
                end else if (read_req) begin
                    state_d = READ_ACTIVE;
                end
            end
            READ_ACTIVE: begin
                // Reads are never aborted; a start seen meanwhile (or with the
                // completing pulse) re-initialises once the read finishes.
                if (read_done) begin
                    if (start || start_pending_q) begin
                        start_pending_d = 1'b0;
                        retry_d         = '0;
                        guard_next_d    = INIT_RUN;
                        state_d         = GUARD;
                    end else begin
                        state_d = READY;
                    end
                end else if (start) begin
                    start_pending_d = 1'b1;
                end
            end
            ERROR: begin
                // Pins are already unowned here, so no guard gap is needed.
                if (start) begin
                    retry_d = '0;
                    state_d = INIT_RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode the next state and register it, so they change on the
    // same edge as the state itself.
    always_comb begin
        outs_d = decode_outputs(state_d);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            outs_q <= '0;
        end else begin
            outs_q <= outs_d;
        end
    end

    assign en_init   = outs_q.en_init;
    assign en_read   = outs_q.en_read;
    assign pin_owner = outs_q.pin_owner;
    assign ready     = outs_q.ready;
    assign busy      = outs_q.busy;
    assign error     = outs_q.error;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_flash_sequencer.sv
// Self-checking bench for spi_flash_sequencer. A behavioural model steps on
// every clock edge and queues the expected outputs; a monitor on the falling
// edge pops and compares. Directed sequences follow the test plan, then
// random traffic runs.
module tb_spi_flash_sequencer;

    localparam int QE   = 6;
    localparam int MAXR = 3;
    localparam int TMO  = 24;
    localparam int GRD  = 4;

    localparam int M_IDLE  = 0;
    localparam int M_INIT  = 1;
    localparam int M_CHECK = 2;
    localparam int M_GUARD = 3;
    localparam int M_READY = 4;
    localparam int M_READ  = 5;
    localparam int M_ERROR = 6;

    logic       ACLK = 1'b0;
    logic       ARESETn = 1'b0;
    logic       start = 1'b0;
    logic       init_done = 1'b0;
    logic [7:0] init_status = 8'h00;
    logic       read_req = 1'b0;
    logic       read_done = 1'b0;
    logic       en_init, en_read, ready, busy, error;
    logic [1:0] pin_owner, retry_cnt;
    logic [7:0] status_q;
    logic [2:0] state_dbg;

    spi_flash_sequencer #(
        .QE_BIT       (QE),
        .MAX_RETRY    (MAXR),
        .INIT_TIMEOUT (TMO),
        .GUARD_CYCLES (GRD),
        .AUTO_START   (1)
    ) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .start       (start),
        .init_done   (init_done),
        .init_status (init_status),
        .read_req    (read_req),
        .read_done   (read_done),
        .en_init     (en_init),
        .en_read     (en_read),
        .pin_owner   (pin_owner),
        .ready       (ready),
        .busy        (busy),
        .error       (error),
        .retry_cnt   (retry_cnt),
        .status_q    (status_q),
        .state_dbg   (state_dbg)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [2:0] st;
        logic       en_init;
        logic       en_read;
        logic [1:0] owner;
        logic       rdy;
        logic       bsy;
        logic       err;
        logic [1:0] retry;
        logic [7:0] status;
    } obs_t;

    typedef struct {
        obs_t exp;
        bit   rst;
    } item_t;

    item_t exp_q[$];

    int       m_st = M_IDLE;
    int       m_age = 0;
    int       m_next = M_IDLE;
    int       m_retry = 0;
    logic [7:0] m_status = 8'h00;
    bit       m_ok = 1'b0;
    bit       m_pending = 1'b0;
    bit       m_first = 1'b0;

    task automatic go(input int s);
        m_st  = s;
        m_age = 0;
    endtask

    task automatic model_step();
        item_t it;
        int    old_age;
        bit    first_now;
        if (!ARESETn) begin
            m_st = M_IDLE; m_age = 0; m_next = M_IDLE; m_retry = 0;
            m_status = 8'h00; m_ok = 1'b0; m_pending = 1'b0; m_first = 1'b1;
            it.rst = 1'b1;
        end else begin
            it.rst    = 1'b0;
            first_now = m_first;
            m_first   = 1'b0;
            old_age   = m_age;
            m_age++;
            case (m_st)
                M_IDLE:  if (start || first_now) go(M_INIT);
                M_INIT: begin
                    if (init_done) begin
                        m_status = init_status;
                        m_ok     = init_status[QE];
                        go(M_CHECK);
                    end else if (old_age == TMO - 1) begin
                        m_ok = 1'b0;
                        go(M_CHECK);
                    end
                end
                M_CHECK: begin
                    if (m_ok) begin
                        m_next = M_READY; go(M_GUARD);
                    end else if (m_retry == MAXR) begin
                        go(M_ERROR);
                    end else begin
                        m_retry++; m_next = M_INIT; go(M_GUARD);
                    end
                end
                M_GUARD: if (old_age == GRD - 1) go(m_next);
                M_READY: begin
                    if (start) begin
                        m_retry = 0; m_next = M_INIT; go(M_GUARD);
                    end else if (read_req) begin
                        go(M_READ);
                    end
                end
                M_READ: begin
                    if (read_done) begin
                        if (m_pending || start) begin
                            m_pending = 1'b0; m_retry = 0; m_next = M_INIT; go(M_GUARD);
                        end else begin
                            go(M_READY);
                        end
                    end else if (start) begin
                        m_pending = 1'b1;
                    end
                end
                M_ERROR: if (start) begin m_retry = 0; go(M_INIT); end
                default: go(M_IDLE);
            endcase
        end
        it.exp.st      = 3'(m_st);
        it.exp.en_init = (m_st == M_INIT);
        it.exp.en_read = (m_st == M_READY) || (m_st == M_READ);
        it.exp.owner   = (m_st == M_INIT) ? 2'd1 : (it.exp.en_read ? 2'd2 : 2'd0);
        it.exp.rdy     = it.exp.en_read;
        it.exp.bsy     = (m_st == M_READ);
        it.exp.err     = (m_st == M_ERROR);
        it.exp.retry   = 2'(m_retry);
        it.exp.status  = m_status;
        exp_q.push_back(it);
    endtask

    initial begin
        forever begin
            @(posedge ACLK);
            model_step();
        end
    end

    // ---------------- monitor ----------------
    initial begin
        item_t      it;
        obs_t       act;
        logic [1:0] last_owner = 2'd0;
        int         zero_run = 0;
        forever begin
            @(negedge ACLK);
            if (exp_q.size() > 0) begin
                it  = exp_q.pop_front();
                act = {state_dbg, en_init, en_read, pin_owner, ready, busy, error, retry_cnt, status_q};
                n_checks++;
                if (act !== it.exp) begin
                    n_errors++;
                    $display("FAIL scoreboard t=%0t: got st=%0d ei=%b er=%b own=%0d rdy=%b bsy=%b err=%b rc=%0d sq=%02h, expected st=%0d ei=%b er=%b own=%0d rdy=%b bsy=%b err=%b rc=%0d sq=%02h",
                             $time, act.st, act.en_init, act.en_read, act.owner, act.rdy, act.bsy, act.err, act.retry, act.status,
                             it.exp.st, it.exp.en_init, it.exp.en_read, it.exp.owner, it.exp.rdy, it.exp.bsy, it.exp.err, it.exp.retry, it.exp.status);
                end
                // Pin ownership may only swap engines after a full guard gap;
                // reset is the one exception.
                if (it.rst) begin
                    last_owner = 2'd0;
                    zero_run   = 0;
                end else if (pin_owner == 2'd0) begin
                    zero_run++;
                end else begin
                    if (last_owner != 2'd0 && pin_owner != last_owner)
                        check("guard_gap", 32'(zero_run >= GRD), 32'd1);
                    last_owner = pin_owner;
                    zero_run   = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input string name);
        int n = 0;
        while (state_dbg !== s && n < 200) begin
            tick(1);
            n++;
        end
        if (state_dbg !== s) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: timed out waiting for state %0d, still %0d", name, s, state_dbg);
        end
    endtask

    initial begin
        int n;
        repeat (3) @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        // cycle 0: reset state
        check("reset_state", 32'(state_dbg), 32'd0);
        check("reset_outputs", 32'({en_init, en_read, pin_owner, ready, busy, error, retry_cnt}), 32'd0);
        check("reset_status_q", 32'(status_q), 32'd0);

        // 1. auto-start pass
        tick(1);
        check("auto_en_init_c1", 32'(en_init), 32'd1);
        check("auto_owner_c1", 32'(pin_owner), 32'd1);
        tick(19);
        check("auto_en_init_c20", 32'(en_init), 32'd1);
        init_done = 1'b1; init_status = 8'h40;
        tick(1);
        init_done = 1'b0;
        check("auto_check_c21", 32'(state_dbg), 32'd2);
        tick(1);
        check("auto_guard_c22", 32'({state_dbg, pin_owner}), 32'({3'd3, 2'd0}));
        tick(3);
        check("auto_guard_c25", 32'({state_dbg, pin_owner}), 32'({3'd3, 2'd0}));
        tick(1);
        check("auto_ready_c26", 32'({ready, en_read, pin_owner}), 32'({1'b1, 1'b1, 2'd2}));
        check("auto_status_q", 32'(status_q), 32'h40);
        check("auto_retry", 32'(retry_cnt), 32'd0);

        // 4. read handshake
        read_req = 1'b1;
        tick(1);
        read_req = 1'b0;
        check("read_busy_first", 32'(busy), 32'd1);
        tick(9);
        check("read_busy_last", 32'({busy, pin_owner}), 32'({1'b1, 2'd2}));
        read_done = 1'b1;
        tick(1);
        read_done = 1'b0;
        check("read_back_ready", 32'({state_dbg, busy, ready}), 32'({3'd4, 1'b0, 1'b1}));

        // 5. start during a read
        read_req = 1'b1;
        tick(1);
        read_req = 1'b0;
        tick(3);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(4);
        check("pending_read_alive", 32'({state_dbg, en_read}), 32'({3'd5, 1'b1}));
        read_done = 1'b1;
        tick(1);
        read_done = 1'b0;
        check("pending_guard", 32'({state_dbg, pin_owner, en_read}), 32'({3'd3, 2'd0, 1'b0}));
        tick(3);
        check("pending_guard_end", 32'(pin_owner), 32'd0);
        tick(1);
        check("pending_reinit", 32'({state_dbg, retry_cnt, pin_owner}), 32'({3'd1, 2'd0, 2'd1}));

        // 2. QE failure and retries
        for (int a = 0; a <= MAXR; a++) begin
            wait_state(3'd1, "qe_wait_init");
            check("qe_retry_cnt", 32'(retry_cnt), 32'(a));
            tick(5);
            init_done = 1'b1;
            init_status = 8'($urandom) & ~(8'h01 << QE);
            tick(1);
            init_done = 1'b0;
        end
        wait_state(3'd6, "qe_wait_error");
        check("qe_error", 32'({error, en_init, en_read, pin_owner, retry_cnt}),
              32'({1'b1, 1'b0, 1'b0, 2'd0, 2'd3}));
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("qe_restart", 32'({state_dbg, retry_cnt, error}), 32'({3'd1, 2'd0, 1'b0}));

        // 3. timeout
        for (int a = 0; a <= MAXR; a++) begin
            wait_state(3'd1, "tmo_wait_init");
            check("tmo_retry_cnt", 32'(retry_cnt), 32'(a));
            n = 0;
            while (state_dbg === 3'd1 && n < 100) begin
                tick(1);
                n++;
            end
            check("tmo_run_len", 32'(n), 32'(TMO));
            check("tmo_to_check", 32'(state_dbg), 32'd2);
        end
        wait_state(3'd6, "tmo_wait_error");
        check("tmo_error", 32'(error), 32'd1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(TMO - 1);
        init_done = 1'b1; init_status = 8'h40;
        tick(1);
        init_done = 1'b0;
        check("tmo_edge_check", 32'(state_dbg), 32'd2);
        tick(1);
        check("tmo_edge_pass", 32'({state_dbg, retry_cnt, status_q}), 32'({3'd3, 2'd0, 8'h40}));
        wait_state(3'd4, "tmo_wait_ready");

        // 6. simultaneous start and read_req, then reset mid-init
        start = 1'b1; read_req = 1'b1;
        tick(1);
        start = 1'b0; read_req = 1'b0;
        check("simul_guard", 32'({state_dbg, busy, pin_owner}), 32'({3'd3, 1'b0, 2'd0}));
        wait_state(3'd1, "simul_wait_init");
        tick(3);
        ARESETn = 1'b0;
        tick(1);
        ARESETn = 1'b1;
        check("midreset_outputs", 32'({state_dbg, en_init, en_read, pin_owner, ready, busy, error, retry_cnt, status_q}), 32'd0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            start       = ($urandom_range(0, 39) == 0);
            init_done   = ($urandom_range(0, 5) == 0);
            init_status = 8'($urandom);
            if ($urandom_range(0, 9) < 7) init_status[QE] = 1'b1;
            read_req    = ($urandom_range(0, 3) == 0);
            read_done   = ($urandom_range(0, 5) == 0);
            ARESETn     = ($urandom_range(0, 599) != 0);
            tick(1);
        end
        start = 1'b0; init_done = 1'b0; read_req = 1'b0; read_done = 1'b0; ARESETn = 1'b1;
        tick(5);
        @(negedge ACLK);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
